// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter
// Shares a single SDRAM_controller user port between NUM_PORTS requesters.
// Each transaction passes through IDLE -> WAIT -> DRAIN, so the controller's
// ready-release phase completes before the next grant is issued.
// Winners are picked round-robin, starting the scan at rr_ptr.
// Optional build macro SDRAM_ARBITER_PRIORITY_EN gives port 0 fixed highest
// priority. Port-0 grants then leave rr_ptr unchanged, and the other ports
// keep arbitrating round-robin.
module sdram_request_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [NUM_PORTS-1:0]             i_request,
  input  logic [NUM_PORTS-1:0]             i_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_wdata,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [NUM_PORTS-1:0]             o_ready,
  output logic                             o_busy,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic                             o_sdram_request,
  output logic                             o_sdram_rw,
  output logic [ADDR_WIDTH-1:0]            o_sdram_address,
  output logic [DATA_WIDTH-1:0]            o_sdram_wdata,
  input  logic [DATA_WIDTH-1:0]            i_sdram_rdata,
  input  logic                             i_sdram_ready
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_found;
  logic [PTR_W:0]         cand;
  logic [NUM_PORTS-1:0]   ready_d;
  logic [NUM_PORTS-1:0]   eligible;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = i_address[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[p] = i_wdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // A port that has just completed stays masked during its o_ready cycle and
  // the cycle after, so the requester has time to drop its request line.
  assign eligible = i_request & ~o_ready & ~ready_d;

  assign next_ptr = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Pick the first eligible port, scanning from rr_ptr with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef SDRAM_ARBITER_PRIORITY_EN
    if (eligible[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!win_found && eligible[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Transaction sequencer: latch the winner, wait for the controller, then wait for its ready to release
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      ready_d         <= '0;
      o_rdata         <= '0;
      o_ready         <= '0;
      o_busy          <= 1'b0;
      o_grant         <= '0;
      o_sdram_request <= 1'b0;
      o_sdram_rw      <= 1'b0;
      o_sdram_address <= '0;
      o_sdram_wdata   <= '0;
    end else begin
      ready_d <= o_ready;
      o_ready <= '0;
      case (state)
        IDLE: begin
          if (win_found && !i_sdram_ready) begin
            grant_idx       <= win_idx;
            o_grant         <= NUM_PORTS'(1) << win_idx;
            o_sdram_request <= 1'b1;
            o_sdram_rw      <= i_rw[win_idx];
            o_sdram_address <= addr_arr[win_idx];
            o_sdram_wdata   <= wdata_arr[win_idx];
            o_busy          <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (i_sdram_ready) begin
            o_sdram_request <= 1'b0;
            o_rdata         <= i_sdram_rdata;
            o_ready         <= o_grant;
            state           <= DRAIN;
          end
        end
        DRAIN: begin
          if (!i_sdram_ready) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
`ifdef SDRAM_ARBITER_PRIORITY_EN
            if (grant_idx != '0) begin
              rr_ptr <= next_ptr;
            end
`else
            rr_ptr <= next_ptr;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Testbench for sdram_request_arbiter.
// Directed scenarios are followed by a randomized run that is checked against
// a transaction-level round-robin model. Building with
// SDRAM_ARBITER_PRIORITY_EN switches the model to port-0 priority and adds
// the priority scenario.
module tb_sdram_request_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic [N-1:0]      i_request;
  logic [N-1:0]      i_rw;
  logic [N*AW-1:0]   i_address;
  logic [N*DW-1:0]   i_wdata;
  logic [DW-1:0]     o_rdata;
  logic [N-1:0]      o_ready;
  logic              o_busy;
  logic [N-1:0]      o_grant;
  logic              o_sdram_request;
  logic              o_sdram_rw;
  logic [AW-1:0]     o_sdram_address;
  logic [DW-1:0]     o_sdram_wdata;
  logic [DW-1:0]     i_sdram_rdata;
  logic              i_sdram_ready;

  int checks = 0;
  int errors = 0;

  sdram_request_arbiter #(
    .NUM_PORTS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_request      (i_request),
    .i_rw           (i_rw),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .o_rdata        (o_rdata),
    .o_ready        (o_ready),
    .o_busy         (o_busy),
    .o_grant        (o_grant),
    .o_sdram_request(o_sdram_request),
    .o_sdram_rw     (o_sdram_rw),
    .o_sdram_address(o_sdram_address),
    .o_sdram_wdata  (o_sdram_wdata),
    .i_sdram_rdata  (i_sdram_rdata),
    .i_sdram_ready  (i_sdram_ready)
  );

  // Free-running 100 MHz clock
  always #5 i_clock = ~i_clock;

  // Hard stop in case a scenario hangs
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge i_clock);
  endtask

  task automatic set_port(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_rw[p]             = rw;
    i_address[p*AW +: AW] = a;
    i_wdata[p*DW +: DW]   = d;
  endtask

  function automatic logic [N-1:0] onehot(input int p);
    return N'(1) << p;
  endfunction

  // Reference selection: fixed port-0 priority (optional), then round-robin from ptr
  function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
`ifdef SDRAM_ARBITER_PRIORITY_EN
    if (pend[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (pend[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    i_reset       = 1'b1;
    i_request     = '0;
    i_rw          = '0;
    i_address     = '0;
    i_wdata       = '0;
    i_sdram_ready = 1'b0;
    i_sdram_rdata = '0;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (o_grant !== '0) begin
        g = o_grant;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL grant_timeout: o_grant=%b required nonzero", o_grant);
  endtask

  task automatic raise_ready_wait(input logic [DW-1:0] rd, output logic [N-1:0] rdy,
                                  output logic [DW-1:0] rdat, output logic req, output int lat);
    tick();
    i_sdram_ready = 1'b1;
    i_sdram_rdata = rd;
    rdy = '0;
    rdat = '0;
    req = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (o_ready !== '0) begin
        rdy  = o_ready;
        rdat = o_rdata;
        req  = o_sdram_request;
        lat  = c;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL ready_timeout: o_ready=%b required nonzero", o_ready);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_ready, o_grant, o_busy, o_sdram_request, o_sdram_rw} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b grant=%b busy=%b req=%b rw=%b required all 0",
               o_ready, o_grant, o_busy, o_sdram_request, o_sdram_rw);
    end
    checks++;
    if ({o_rdata, o_sdram_address, o_sdram_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", o_rdata, o_sdram_address, o_sdram_wdata);
    end
  endtask

  task automatic test_single_write();
    logic [N-1:0] g, rdy;
    logic [DW-1:0] rdat;
    logic req;
    int lat;
    do_reset();
    set_port(1, 1'b1, 32'h0001_0000, 32'hcafe_babe);
    i_request[1] = 1'b1;
    wait_grant(g);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("[TB] FAIL write_grant: got %b required 0010", g); end
    checks++;
    if (o_sdram_address !== 32'h0001_0000 || o_sdram_rw !== 1'b1 || o_sdram_wdata !== 32'hcafe_babe) begin
      errors++;
      $display("[TB] FAIL write_fields: addr=%h rw=%b wdata=%h required 00010000 1 cafebabe",
               o_sdram_address, o_sdram_rw, o_sdram_wdata);
    end
    checks++;
    if (o_sdram_request !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_req: req=%b busy=%b required 1 1", o_sdram_request, o_busy);
    end
    raise_ready_wait(32'h5a5a_0001, rdy, rdat, req, lat);
    checks++;
    if (rdy !== 4'b0010 || lat !== 1) begin
      errors++;
      $display("[TB] FAIL write_ready: got %b after %0d cycles required 0010 after 1", rdy, lat);
    end
    checks++;
    if (req !== 1'b0 || rdat !== 32'h5a5a_0001) begin
      errors++;
      $display("[TB] FAIL write_complete: req=%b rdata=%h required 0 5a5a0001", req, rdat);
    end
    i_request[1] = 1'b0;
    tick();
    checks++;
    if (o_ready !== 4'b0000 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_pulse: ready=%b busy=%b required 0000 1", o_ready, o_busy);
    end
    i_sdram_ready = 1'b0;
    tick();
    checks++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_release: grant=%b busy=%b required 0000 0", o_grant, o_busy);
    end
    tick();
  endtask

  task automatic test_readback();
    logic [N-1:0] g, rdy;
    logic [DW-1:0] rdat;
    logic req;
    int lat;
    set_port(2, 1'b0, 32'h0001_0000, 32'h0);
    i_request[2] = 1'b1;
    wait_grant(g);
    checks++;
    if (g !== 4'b0100 || o_sdram_rw !== 1'b0 || o_sdram_address !== 32'h0001_0000) begin
      errors++;
      $display("[TB] FAIL read_grant: grant=%b rw=%b addr=%h required 0100 0 00010000", g, o_sdram_rw, o_sdram_address);
    end
    raise_ready_wait(32'hcafe_babe, rdy, rdat, req, lat);
    checks++;
    if (rdy !== 4'b0100 || rdat !== 32'hcafe_babe || req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_complete: ready=%b rdata=%h req=%b required 0100 cafebabe 0", rdy, rdat, req);
    end
    i_request[2] = 1'b0;
    i_sdram_ready = 1'b0;
    i_sdram_rdata = 32'h0;
    repeat (2) tick();
    checks++;
    if (o_rdata !== 32'hcafe_babe || o_grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL read_hold: rdata=%h grant=%b required cafebabe 0000", o_rdata, o_grant);
    end
  endtask

  task automatic test_contention();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] g, rdy;
    logic [DW-1:0] rdat;
    logic req;
    int lat;
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(32'h100 * (p + 1)), '0);
    i_request = '1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      checks++;
      if (g !== onehot(exp_order[k]) || o_sdram_address !== AW'(32'h100 * (exp_order[k] + 1))) begin
        errors++;
        $display("[TB] FAIL contention_order[%0d]: grant=%b addr=%h required %b %h", k, g, o_sdram_address,
                 onehot(exp_order[k]), AW'(32'h100 * (exp_order[k] + 1)));
      end
      raise_ready_wait(DW'(k), rdy, rdat, req, lat);
      checks++;
      if (rdy !== onehot(exp_order[k])) begin
        errors++;
        $display("[TB] FAIL contention_ready[%0d]: got %b required %b", k, rdy, onehot(exp_order[k]));
      end
      i_request[exp_order[k]] = 1'b0;
      i_sdram_ready = 1'b0;
      if (k == 0) begin
        tick();
        i_request[0] = 1'b1;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_wraparound();
    int exp_order[6] = '{3, 0, 3, 0, 3, 0};
    logic [N-1:0] g, rdy;
    logic [DW-1:0] rdat;
    logic req;
    int lat;
    do_reset();
    set_port(2, 1'b0, 32'h20, '0);
    i_request[2] = 1'b1;
    wait_grant(g);
    raise_ready_wait(32'h0, rdy, rdat, req, lat);
    i_request[2] = 1'b0;
    i_sdram_ready = 1'b0;
    repeat (2) tick();
    set_port(3, 1'b1, 32'h30, 32'h3333);
    set_port(0, 1'b0, 32'h40, 32'h0);
    i_request[3] = 1'b1;
    i_request[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      checks++;
      if (g !== onehot(exp_order[k])) begin
        errors++;
        $display("[TB] FAIL wrap_order[%0d]: grant=%b required %b", k, g, onehot(exp_order[k]));
      end
      raise_ready_wait(32'h0, rdy, rdat, req, lat);
      i_request[exp_order[k]] = 1'b0;
      i_sdram_ready = 1'b0;
      tick();
      i_request[exp_order[k]] = 1'b1;
    end
    i_request = '0;
    repeat (3) tick();
  endtask

  task automatic test_stale_ready_reset();
    logic [N-1:0] g;
    do_reset();
    i_sdram_ready = 1'b1;
    set_port(0, 1'b1, 32'hdead_0000, 32'h1234_5678);
    i_request[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (o_grant !== 4'b0000 || o_sdram_request !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stale_ready[%0d]: grant=%b req=%b required 0000 0", c, o_grant, o_sdram_request);
      end
    end
    i_sdram_ready = 1'b0;
    wait_grant(g);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("[TB] FAIL stale_release: grant=%b required 0001", g); end
    i_reset = 1'b1;
    tick();
    checks++;
    if ({o_ready, o_grant, o_busy, o_sdram_request, o_sdram_rw, o_sdram_address, o_sdram_wdata, o_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset: ready=%b grant=%b busy=%b req=%b addr=%h wdata=%h required all 0",
               o_ready, o_grant, o_busy, o_sdram_request, o_sdram_address, o_sdram_wdata);
    end
    i_reset = 1'b0;
    i_request = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (o_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL midreset_noready[%0d]: ready=%b required 0000", c, o_ready);
      end
    end
  endtask

`ifdef SDRAM_ARBITER_PRIORITY_EN
  task automatic test_priority();
    logic [N-1:0] g, rdy;
    logic [DW-1:0] rdat;
    logic req;
    int lat;
    do_reset();
    set_port(0, 1'b0, 32'h0, '0);
    set_port(2, 1'b0, 32'h2, '0);
    i_request[0] = 1'b1;
    i_request[2] = 1'b1;
    // Slow ready release lets port 0's masking window expire inside DRAIN
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin errors++; $display("[TB] FAIL prio_hold[%0d]: grant=%b required 0001", k, g); end
      raise_ready_wait(32'h0, rdy, rdat, req, lat);
      i_request[0] = 1'b0;
      tick();
      i_request[0] = 1'b1;
      tick();
      i_sdram_ready = 1'b0;
    end
    // Fast release: port 0 is still masked at the first IDLE decision
    wait_grant(g);
    raise_ready_wait(32'h0, rdy, rdat, req, lat);
    i_request[0] = 1'b0;
    i_sdram_ready = 1'b0;
    tick();
    i_request[0] = 1'b1;
    wait_grant(g);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("[TB] FAIL prio_window: grant=%b required 0100", g); end
    raise_ready_wait(32'h0, rdy, rdat, req, lat);
    i_request[2] = 1'b0;
    i_sdram_ready = 1'b0;
    tick();
    i_request[2] = 1'b1;
    wait_grant(g);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("[TB] FAIL prio_return: grant=%b required 0001", g); end
    raise_ready_wait(32'h0, rdy, rdat, req, lat);
    i_request = '0;
    i_sdram_ready = 1'b0;
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0]  pending;
    logic          p_rw    [N];
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    int            waited  [N];
    logic [N-1:0]  prev_grant;
    logic [DW-1:0] exp_rd;
    int mdl_rr, cur, exp_p, idle_cnt, ctrl_delay, served, bound;
`ifdef SDRAM_ARBITER_PRIORITY_EN
    bound = 2 * N;
`else
    bound = N - 1;
`endif
    do_reset();
    pending = '0;
    mdl_rr = 0; cur = -1; idle_cnt = 0; ctrl_delay = 0; served = 0;
    prev_grant = '0;
    exp_rd = '0;
    for (int p = 0; p < N; p++) begin
      waited[p] = 0; p_rw[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (o_grant !== '0 && prev_grant === '0) begin
        exp_p = model_pick(pending, mdl_rr);
        checks++;
        if (exp_p < 0 || o_grant !== onehot(exp_p)) begin
          errors++;
          $display("[TB] FAIL rand_grant cyc %0d: grant=%b required port %0d (pending %b ptr %0d)",
                   cyc, o_grant, exp_p, pending, mdl_rr);
        end else begin
          cur = exp_p;
          checks++;
          if (o_sdram_address !== p_addr[cur] || o_sdram_rw !== p_rw[cur] ||
              (p_rw[cur] && o_sdram_wdata !== p_wdata[cur])) begin
            errors++;
            $display("[TB] FAIL rand_fields cyc %0d: addr=%h rw=%b wdata=%h required %h %b %h",
                     cyc, o_sdram_address, o_sdram_rw, o_sdram_wdata, p_addr[cur], p_rw[cur], p_wdata[cur]);
          end
          checks++;
          if (waited[cur] > bound) begin
            errors++;
            $display("[TB] FAIL rand_starve: port %0d waited %0d grants required <= %0d", cur, waited[cur], bound);
          end
          waited[cur] = 0;
          for (int q = 0; q < N; q++) if (pending[q] && q != cur) waited[q]++;
          ctrl_delay = $urandom_range(0, 3);
        end
      end
      prev_grant = o_grant;
      if (o_ready !== '0) begin
        checks++;
        if (cur < 0 || o_ready !== onehot(cur) || o_rdata !== exp_rd || o_sdram_request !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_complete cyc %0d: ready=%b rdata=%h req=%b required port %0d rdata %h req 0",
                   cyc, o_ready, o_rdata, o_sdram_request, cur, exp_rd);
        end
        if (cur >= 0) begin
          pending[cur] = 1'b0;
          i_request[cur] = 1'b0;
`ifdef SDRAM_ARBITER_PRIORITY_EN
          if (cur != 0) mdl_rr = (cur + 1) % N;
`else
          mdl_rr = (cur + 1) % N;
`endif
          cur = -1;
        end
        served++;
      end
      if (o_sdram_request && !i_sdram_ready) begin
        if (ctrl_delay == 0) begin
          exp_rd = $urandom;
          i_sdram_rdata = exp_rd;
          i_sdram_ready = 1'b1;
        end else begin
          ctrl_delay--;
        end
      end else if (i_sdram_ready && !o_sdram_request) begin
        if ($urandom_range(0, 1) == 1) i_sdram_ready = 1'b0;
      end
      idle_cnt = o_busy ? 0 : idle_cnt + 1;
      if ((o_sdram_request === 1'b1 || idle_cnt >= 2) && cyc < 3800) begin
        for (int q = 0; q < N; q++) begin
          if (!pending[q] && $urandom_range(0, 3) == 0) begin
            pending[q] = 1'b1;
            p_rw[q]    = 1'($urandom_range(0, 1));
            p_addr[q]  = AW'($urandom_range(0, 7) * 4);
            p_wdata[q] = $urandom;
            set_port(q, p_rw[q], p_addr[q], p_wdata[q]);
            i_request[q] = 1'b1;
          end
        end
      end
    end
    checks++;
    if (served < 100) begin
      errors++;
      $display("[TB] FAIL rand_throughput: served %0d transactions required >= 100", served);
    end
    i_request = '0;
    i_sdram_ready = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_wraparound();
    test_stale_ready_reset();
`ifdef SDRAM_ARBITER_PRIORITY_EN
    test_priority();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_request_arbiter.md
Name: sdram_request_arbiter

Overview:
Round-robin arbiter that shares one SDRAM_controller user port between NUM_PORTS requesters (CPU I/D, video, DMA).
- Sits directly in front of SDRAM_controller.
- Presents a level request/ready handshake to each requester.
- Sequences exactly one downstream transaction at a time, including the controller's ready-release phase.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, user data width; matches SDRAM_controller USER_DATA_WIDTH

Ports:
i_clock  in  1  system clock (same domain as SDRAM_controller i_clock)
i_reset  in  1  synchronous, active-high reset
i_request  in  NUM_PORTS  per-port request, held high until that port's o_ready
i_rw  in  NUM_PORTS  per-port direction, 1=write, 0=read
i_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
i_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
o_rdata  out  DATA_WIDTH  read data, shared by all ports, valid with o_ready
o_ready  out  NUM_PORTS  one-hot, single-cycle completion pulse
o_busy  out  1  high while not IDLE
o_grant  out  NUM_PORTS  one-hot owner of the current transaction, 0 in IDLE
o_sdram_request  out  1  to SDRAM_controller i_request
o_sdram_rw  out  1  to i_rw
o_sdram_address  out  ADDR_WIDTH  to i_address
o_sdram_wdata  out  DATA_WIDTH  to i_wdata
i_sdram_rdata  in  DATA_WIDTH  from o_rdata
i_sdram_ready  in  1  from o_ready; stays high until request drops

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state=IDLE; rr_ptr=0.
- States:
  - IDLE: if any eligible request, select a winner, latch its rw/address/wdata into the o_sdram_* registers, set o_grant, set o_sdram_request=1, go to WAIT. Otherwise stay.
  - WAIT: hold o_sdram_request and all latched fields stable. On i_sdram_ready=1: o_sdram_request<=0, o_rdata<=i_sdram_rdata (also on writes), o_ready[grant]<=1 for one cycle, go to DRAIN.
  - DRAIN: wait for i_sdram_ready=0. Then o_grant<=0, rr_ptr<=(grant index+1) mod NUM_PORTS, go to IDLE.
- Selection: first requesting port scanning rr_ptr, rr_ptr+1, ... with wrap-around.
- Eligibility: a port is ineligible in the cycle its o_ready pulse is high and in the following cycle. This covers requester de-assert latency and prevents double service.
- Latency: request sampled at edge 0 -> o_sdram_request high after edge 0; i_sdram_ready sampled high at edge k -> o_ready high for cycle k+1. Minimum per-transaction occupancy is 3 cycles plus controller time.
- Simultaneous requests: exactly one grant; the others stay pending with their inputs untouched. No starvation: each pending port is served within NUM_PORTS grants.
- Request changes: a request dropped by a non-granted port before grant is simply not served. A granted port's input changes after the IDLE latch are ignored.
- i_sdram_ready high while in IDLE (stale): no grant is issued until it is low.
- Reset mid-transaction: return to reset values next cycle, no o_ready pulse. The outstanding controller transaction is abandoned; the SDRAM_controller is reset by the same i_reset.
- o_rdata holds its last value between transactions.

Optional Feature:
SDRAM_ARBITER_PRIORITY_EN
- Defined: port 0 is fixed highest priority. Whenever port 0 is eligible in IDLE it wins; remaining ports arbitrate round-robin. rr_ptr is not advanced by port-0 grants.
- Undefined: pure round-robin across all ports as described above.

Test Plan:
- Single write: port 1 writes address 0x00010000, data 0xcafebabe → o_sdram_address=0x00010000, o_sdram_rw=1, o_grant=0010; o_ready=0010 for exactly one cycle, 1 cycle after i_sdram_ready rises.
- Read-back: port 2 reads 0x00010000 → o_rdata=0xcafebabe with o_ready=0100; o_sdram_request falls the cycle after ready.
- Contention: ports 0–3 request together from reset → grant order 0,1,2,3. Port 0 re-requests immediately → served after port 3, not before.
- Wrap-around/fairness: ports 3 and 0 request continuously, rr_ptr=3 → alternating 3,0,3,0; never two consecutive grants to the same port.
- Stale ready and reset: hold i_sdram_ready=1 in IDLE with port 0 requesting → no grant until ready falls. Assert i_reset in WAIT → next cycle all outputs 0, no o_ready pulse.
- With SDRAM_ARBITER_PRIORITY_EN: ports 0 and 2 request continuously → sequence 0,0,... while port 0 is eligible; port 2 is granted only in port 0's ineligible window.
